axis_32to64_strb: RTL and testbench

//  Packs a 32-bit AXI-Stream into a 64-bit AXI-Stream and generates TSTRB for odd-length packets.
//  The first 32-bit word goes to the low half [31:0] and the second to the high half [63:32].
//  Per-packet SRCDEST is captured and carried on TUSER.

---
 rtl/axis_32to64_strb.sv | 151 +++++++++++++++
 tb/tb_axis_32to64_strb.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_32to64_strb.sv
// axis_32to64_strb: packs a 32-bit AXI-Stream into 64-bit beats.
// The first word of each pair lands in [31:0], the second in [63:32]. A packet with an
// odd word count ends in a low-half-only beat (TSTRB = 8'h0F). The SRCDEST tag seen on
// the first word of a packet is carried on TUSER for every beat of that packet.
module axis_32to64_strb #(
  parameter int unsigned SRCDEST_W = 32,
  parameter bit          ZERO_PAD  = 1'b1
) (
  input  logic                 AXIS_ACLK,
  input  logic                 AXIS_ARESET,
  input  logic [31:0]          S_AXIS_TDATA,
  input  logic                 S_AXIS_TLAST,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  input  logic [SRCDEST_W-1:0] SRCDEST,
  output logic [63:0]          M_AXIS_TDATA,
  output logic [7:0]           M_AXIS_TSTRB,
  output logic                 M_AXIS_TLAST,
  output logic [SRCDEST_W-1:0] M_AXIS_TUSER,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY
);

  // StLo: waiting for the low word; StHi: waiting for the high word;
  // StPush: emitting the strobed tail beat of an odd-length packet.
  typedef enum logic [1:0] {
    StLo   = 2'd0,
    StHi   = 2'd1,
    StPush = 2'd2
  } state_e;

  state_e                 state_q;
  logic [31:0]            lo_q;
  logic [SRCDEST_W-1:0]   user_q;
  logic                   in_pkt_q;

  logic [63:0]            m_data_q;
  logic [7:0]             m_strb_q;
  logic                   m_last_q;
  logic [SRCDEST_W-1:0]   m_user_q;
  logic                   m_valid_q;

  logic                   out_free;
  logic                   s_ready;
  logic                   s_xfr;
  logic                   m_xfr;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !m_valid_q || M_AXIS_TREADY;
  assign s_xfr    = S_AXIS_TVALID && s_ready;
  assign m_xfr    = m_valid_q && M_AXIS_TREADY;

  // Input ready is a function of state and downstream space only, never of TVALID/TDATA.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      StLo:    s_ready = 1'b1;
      StHi:    s_ready = out_free;
      StPush:  s_ready = 1'b0;
      default: s_ready = 1'b0;
    endcase
  end

  // Packing FSM together with the registered output beat.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state_q   <= StLo;
      lo_q      <= 32'h0;
      user_q    <= '0;
      in_pkt_q  <= 1'b0;
      m_data_q  <= 64'h0;
      m_strb_q  <= 8'h0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      // Drain first; a reload below in the same cycle takes precedence.
      if (m_xfr) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        StLo: begin
          if (s_xfr) begin
            lo_q <= S_AXIS_TDATA;
            // The routing tag is taken only on the first word of a packet.
            if (!in_pkt_q) begin
              user_q <= SRCDEST;
            end
            if (S_AXIS_TLAST) begin
              state_q  <= StPush;
              in_pkt_q <= 1'b0;
            end else begin
              state_q  <= StHi;
              in_pkt_q <= 1'b1;
            end
          end
        end

        StHi: begin
          if (s_xfr) begin
            m_data_q  <= {S_AXIS_TDATA, lo_q};
            m_strb_q  <= 8'hFF;
            m_last_q  <= S_AXIS_TLAST;
            m_user_q  <= user_q;
            m_valid_q <= 1'b1;
            state_q   <= StLo;
            if (S_AXIS_TLAST) begin
              in_pkt_q <= 1'b0;
            end
          end
        end

        StPush: begin
          if (out_free) begin
            // Upper half is either cleared or left holding the previous beat's data.
            m_data_q  <= {(ZERO_PAD ? 32'h0 : m_data_q[63:32]), lo_q};
            m_strb_q  <= 8'h0F;
            m_last_q  <= 1'b1;
            m_user_q  <= user_q;
            m_valid_q <= 1'b1;
            state_q   <= StLo;
          end
        end

        default: begin
          state_q <= StLo;
        end
      endcase
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TSTRB  = m_strb_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign M_AXIS_TUSER  = m_user_q;
  assign M_AXIS_TVALID = m_valid_q;

`ifndef SYNTHESIS
  // A stalled output beat must hold every field until it is taken.
  property p_out_stable;
    @(posedge AXIS_ACLK) disable iff (AXIS_ARESET)
      (M_AXIS_TVALID && !M_AXIS_TREADY) |=>
        (M_AXIS_TVALID && $stable(M_AXIS_TDATA) && $stable(M_AXIS_TSTRB) &&
         $stable(M_AXIS_TLAST) && $stable(M_AXIS_TUSER));
  endproperty
  a_out_stable: assert property (p_out_stable);
`endif

endmodule

// File: tb/tb_axis_32to64_strb.sv
// Bench for axis_32to64_strb: directed scenarios plus a long randomized run, with all
// expected beats produced by a packet-level model of the 32->64 packing rules.
module tb_axis_32to64_strb;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [31:0] user;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [31:0] user;
  } word_t;

  logic        clk;
  logic        rst;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] srcdest;
  logic [63:0] m_data;
  logic [7:0]  m_strb;
  logic        m_last;
  logic [31:0] m_user;
  logic        m_valid;
  logic        m_ready;

  word_t stim_q[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    rd_idx;
  int    stalls;
  int    checks;
  int    errors;

  axis_32to64_strb #(
    .SRCDEST_W(32),
    .ZERO_PAD (1'b1)
  ) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESET  (rst),
    .S_AXIS_TDATA (s_data),
    .S_AXIS_TLAST (s_last),
    .S_AXIS_TVALID(s_valid),
    .S_AXIS_TREADY(s_ready),
    .SRCDEST      (srcdest),
    .M_AXIS_TDATA (m_data),
    .M_AXIS_TSTRB (m_strb),
    .M_AXIS_TLAST (m_last),
    .M_AXIS_TUSER (m_user),
    .M_AXIS_TVALID(m_valid),
    .M_AXIS_TREADY(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output beat that is handed over at the coming rising edge.
  always @(negedge clk) begin
    beat_t b;
    if (!rst && m_valid && m_ready) begin
      b.data = m_data;
      b.strb = m_strb;
      b.last = m_last;
      b.user = m_user;
      obs_q.push_back(b);
    end
  end

  // Packet-level model: pair words low-then-high; an odd tail becomes a 0x0F beat.
  task automatic add_packet(input logic [31:0] words[$], input logic [31:0] user);
    word_t w;
    beat_t b;
    int    n;
    n = words.size();
    for (int i = 0; i < n; i++) begin
      w.data = words[i];
      w.last = (i == n - 1);
      w.user = user;
      stim_q.push_back(w);
    end
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) begin
        b.data = {words[i+1], words[i]};
        b.strb = 8'hFF;
        b.last = (i + 2 == n);
      end else begin
        b.data = {32'h0, words[i]};
        b.strb = 8'h0F;
        b.last = 1'b1;
      end
      b.user = user;
      exp_q.push_back(b);
    end
  endtask

  task automatic add_random_packet(input int len);
    logic [31:0] w[$];
    for (int i = 0; i < len; i++) w.push_back($urandom);
    add_packet(w, $urandom);
  endtask

  // Source driver: one word per handshake, SRCDEST scrambled on non-first words.
  task automatic send_all(input bit gaps);
    word_t w;
    bit    first;
    bit    xfr;
    first = 1'b1;
    while (stim_q.size() > 0) begin
      w = stim_q.pop_front();
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      s_valid = 1'b1;
      s_data  = w.data;
      s_last  = w.last;
      srcdest = first ? w.user : $urandom;
      xfr     = 1'b0;
      for (int c = 0; c < 2000 && !xfr; c++) begin
        @(negedge clk);
        xfr = s_ready;
        if (!xfr) stalls++;
        @(posedge clk);
        #1;
      end
      if (!xfr) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: word %h not accepted within 2000 cycles", w.data);
        stim_q.delete();
      end
      first = w.last;
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    m_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 32'h0;
    s_last  = 1'b0;
    srcdest = 32'h0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    checks++;
    if (m_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", m_data); end
    checks++;
    if (m_strb !== 8'h0 || m_last !== 1'b0) begin
      errors++; $display("FAIL reset_strb_last: got %h/%b want 00/0", m_strb, m_last);
    end
    checks++;
    if (m_user !== 32'h0) begin errors++; $display("FAIL reset_user: got %h want 0", m_user); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready: got %b want 1", s_ready); end
  endtask

  task automatic test_full_packet();
    logic [31:0] w[$];
    int          c;
    w = {32'h11, 32'h22, 32'h33, 32'h44};
    add_packet(w, 32'hA5);
    fork
      send_all(1'b0);
      begin
        m_ready = 1'b1;
        for (c = 0; c < 50; c++) begin
          @(negedge clk);
          if (s_valid && s_ready) break;
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL latency_early: valid %b want 0", m_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL latency_2cyc: valid %b want 1", m_valid); end
        for (c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) begin
          @(posedge clk);
          #1;
        end
      end
    join
    idle(3);
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL full_beat %0d: missing, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL full_beat %0d: got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  // Odd packet followed directly by another: the tail push costs exactly one stall.
  task automatic test_odd_packet();
    logic [31:0] w[$];
    w = {32'h1, 32'h2, 32'h3};
    add_packet(w, 32'h01);
    w = {32'h4, 32'h5};
    add_packet(w, 32'h02);
    stalls  = 0;
    m_ready = 1'b1;
    fork
      send_all(1'b0);
      for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) begin
        @(posedge clk);
        #1;
      end
    join
    idle(3);
    checks++;
    if (stalls != 1) begin errors++; $display("FAIL odd_stall: got %0d want 1", stalls); end
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL odd_beat %0d: missing, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL odd_beat %0d: got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL odd_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w[$];
    w = {32'hDEADBEEF};
    add_packet(w, 32'h5A);
    w = {32'hAAAA0001, 32'hAAAA0002};
    add_packet(w, 32'h7);
    stalls  = 0;
    m_ready = 1'b1;
    fork
      send_all(1'b0);
      for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) begin
        @(posedge clk);
        #1;
      end
    join
    idle(3);
    checks++;
    if (stalls != 1) begin errors++; $display("FAIL single_stall: got %0d want 1", stalls); end
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL single_beat %0d: missing, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL single_beat %0d: got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    beat_t snap;
    beat_t cur;
    bit    snap_ok;
    bit    seen_low;
    add_random_packet(8);
    snap_ok  = 1'b0;
    seen_low = 1'b0;
    fork
      send_all(1'b0);
      for (int c = 0; c < 200 && obs_q.size() < exp_q.size(); c++) begin
        m_ready = !(c >= 3 && c < 8);
        @(negedge clk);
        if (c >= 3 && c < 8 && m_valid) begin
          cur.data = m_data;
          cur.strb = m_strb;
          cur.last = m_last;
          cur.user = m_user;
          if (!snap_ok) begin
            snap    = cur;
            snap_ok = 1'b1;
          end else begin
            checks++;
            if (cur !== snap) begin
              errors++; $display("FAIL bp_stable cycle %0d: got %h want %h", c, cur, snap);
            end
          end
          if (!s_ready) seen_low = 1'b1;
        end
        @(posedge clk);
        #1;
      end
    join
    idle(3);
    checks++;
    if (!seen_low) begin errors++; $display("FAIL bp_sready_drop: got never-low want low"); end
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL bp_beat %0d: missing, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL bp_beat %0d: got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  // One word of a packet, then reset: the partial packet must vanish.
  task automatic test_reset_mid_packet();
    word_t       pw;
    logic [31:0] w[$];
    m_ready = 1'b1;
    pw.data = 32'hCAFE0001;
    pw.last = 1'b0;
    pw.user = 32'h11;
    stim_q.push_back(pw);
    send_all(1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", m_valid); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_sready: got %b want 1", s_ready); end
    w = {32'hB0B0000A, 32'hB0B0000B};
    add_packet(w, 32'h3C);
    fork
      send_all(1'b0);
      for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) begin
        @(posedge clk);
        #1;
      end
    join
    idle(3);
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL rst_mid_beat %0d: missing, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL rst_mid_beat %0d: got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rst_mid_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  // Continuous source and sink: only odd packets followed by more traffic may stall.
  task automatic test_back_to_back();
    int len;
    int want_stalls;
    want_stalls = 0;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 17);
      if (p < 19 && (len % 2) == 1) want_stalls++;
      add_random_packet(len);
    end
    stalls  = 0;
    m_ready = 1'b1;
    fork
      send_all(1'b0);
      for (int c = 0; c < 2000 && obs_q.size() < exp_q.size(); c++) begin
        @(posedge clk);
        #1;
      end
    join
    idle(3);
    checks++;
    if (stalls != want_stalls) begin
      errors++; $display("FAIL b2b_stalls: got %0d want %0d", stalls, want_stalls);
    end
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL b2b_beat %0d: missing, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL b2b_beat %0d: got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    bit done;
    for (int p = 0; p < 1000; p++) add_random_packet($urandom_range(1, 17));
    done = 1'b0;
    fork
      send_all(1'b1);
      begin
        for (int c = 0; c < 60000 && !done; c++) begin
          m_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
          done = (obs_q.size() >= exp_q.size());
        end
        checks++;
        if (!done) begin
          errors++; $display("FAIL rand_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size());
        end
      end
    join
    idle(3);
    while (rd_idx < exp_q.size()) begin
      checks++;
      if (rd_idx >= obs_q.size()) begin
        errors++; $display("FAIL rand_beat %0d: missing, want %h", rd_idx, exp_q[rd_idx]);
      end else if (obs_q[rd_idx] !== exp_q[rd_idx]) begin
        errors++;
        $display("FAIL rand_beat %0d: got %h want %h", rd_idx, obs_q[rd_idx], exp_q[rd_idx]);
      end
      rd_idx++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rd_idx = 0;
    stalls = 0;
    test_reset();
    test_full_packet();
    test_odd_packet();
    test_single_word();
    test_backpressure();
    test_reset_mid_packet();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
